sa_window_feeder: RTL and testbench
===================================

Name: sa_window_feeder

Overview:
- Parametrised input feeder for the systolic array (SA).
- Buffers one IMG x IMG frame of signed pixels, received as a row-major stream with a valid/ready handshake.
- Issues K-row sliding windows column by column onto K SA lanes. Lane k is skewed by k cycles.
- Sits between the image source and the SA west edge. Generalises the fixed 3-lane, 16-bit, unpadded feeder with: configurable width and lanes, flow control, stall-on-underflow, done reporting, and optional zero padding.

Parameters:
- DW, 16: pixel width in bits, signed two's complement.
- IMG, 7: frame side length in pixels; must be >= K.
- K, 3: window height, i.e. number of SA lanes; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  one-cycle pulse; starts a frame when idle
- in_valid  in  1  in_data is valid this cycle
- in_data  in  DW  pixel, row-major order
- in_ready  out  1  feeder accepts a pixel this cycle
- out_bus  out  K*DW  lane k occupies bits [k*DW +: DW]
- out_valid  out  K  per-lane valid, skewed like the data
- srt_sig  out  1  equals out_valid[0]; start strobe to the SA
- busy  out  1  high from the accepted load until done
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state IDLE; all counters 0; in_ready, out_valid, srt_sig, busy and done all 0; out_bus all zeros. Buffer contents are don't-care.
- State IDLE:
  - load=1 -> state FILL, busy=1.
  - load is ignored in every other state.
- State FILL/STREAM (one combined active state):
  - in_ready=1 until IMG*IMG pixels have been accepted, then 0.
  - A pixel is stored only on in_valid && in_ready, at buf[wr_row][wr_col].
  - wr_col wraps at IMG-1 and increments wr_row.
  - rows_stored = wr_row.
- Issue rule:
  - Window row r (0..NR-1), column c (0..NC-1) is issued in a cycle where rows_stored >= r+K. Because of this gate, data is never read from an unwritten row.
  - If the gate is not met, issue stalls: nothing is issued and lane 0 goes invalid.
  - c wraps at NC-1 and increments r.
  - Without padding: NR = IMG-K+1, NC = IMG.
- Output timing:
  - An issue in cycle t drives lane 0 at t+1 with buf[r][c]; lane k carries buf[r+k][c] at t+1+k.
  - out_valid[k] has the same skew.
  - Every lane drives zeros whenever its valid bit is 0.
- Continuous input: lane 0 becomes valid the cycle after the K-th row completes, then stays valid for NR*NC consecutive cycles.
- End of frame: after the last issue (r=NR-1, c=NC-1) the block drains. done pulses for one cycle in the cycle after out_valid[K-1] carries the last element. In that same cycle busy falls and the state returns to IDLE.
- Simultaneous events: a write to row r+K-1 and a read of row r in the same cycle is legal; they touch different rows.
- Reset mid-operation: the block returns immediately to the reset values. A partial frame is discarded and no done is generated.
- Counter widths: $clog2(IMG+2)+1 bits, sized so they never wrap within a frame.

Optional Feature:
- Macro: SA_WINDOW_FEEDER_ZERO_PAD_EN.
- Defined: the logical frame gets a one-pixel zero border. Side P = IMG+2, NR = P-K+1, NC = P.
  - Border samples are generated as zeros, not stored.
  - The issue gate becomes "source rows needed by window row r are stored". The top border row counts as always available.
- Undefined: no border; NR = IMG-K+1, NC = IMG.
- The handshake, skew and done timing are identical in both builds.

Test Plan:
- Continuous frame (DW=16, IMG=7, K=3), pixel = 10*row+col, in_valid held 1:
  - 49 pixels accepted, then in_ready=0.
  - srt_sig high for exactly 35 consecutive cycles.
  - First lane-0 sample is 0; lane 1 shows 10 one cycle later; lane 2 shows 20 two cycles later.
  - Last samples: lane 0 = 46, lane 2 = 66.
  - done pulses once and busy falls in the same cycle.
- Underflow stall: drop in_valid for 5 cycles after pixel 23 (row 3 partly written):
  - Window row 0 completes, then out_valid[0]=0 with lanes at 0 until row 3 is complete.
  - Resumed issue starts with lane 0 = 10.
  - Totals still 35 samples per lane.
- Load while busy: pulse load mid-frame -> no effect; the sample sequence is unchanged and exactly one done occurs.
- Reset mid-stream: assert rst_n=0 during window row 2 -> all outputs 0 the same cycle. A fresh frame afterwards matches the first test exactly.
- Parameter sweep DW=8, IMG=5, K=5 -> NR=1; 5 valid samples per lane; lane 4 first sample = 40.
- SA_WINDOW_FEEDER_ZERO_PAD_EN (IMG=7, K=3):
  - 63 samples per lane.
  - Lane 0 reads 0 for the first 9 cycles.
  - Lane 1 reads 0, 0, 1 ... 6, 0.
  - Lane 2 first row reads 0, 10, 11 ... 16, 0.

Source files
------------

// File: rtl/sa_window_feeder.sv
// sa_window_feeder: buffers one IMG x IMG frame of signed pixels and issues
// K-row sliding windows column by column onto K skewed systolic-array lanes.
// Optional build macro SA_WINDOW_FEEDER_ZERO_PAD_EN adds a one-pixel zero border.
module sa_window_feeder #(
    parameter int unsigned DW  = 16,
    parameter int unsigned IMG = 7,
    parameter int unsigned K   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic [K*DW-1:0] out_bus,
    output logic [K-1:0]    out_valid,
    output logic            srt_sig,
    output logic            busy,
    output logic            done
);
    localparam int unsigned CW = $clog2(IMG + 2) + 1;
`ifdef SA_WINDOW_FEEDER_ZERO_PAD_EN
    localparam int unsigned SIDE = IMG + 2;
`else
    localparam int unsigned SIDE = IMG;
`endif
    localparam int unsigned NR    = SIDE - K + 1;
    localparam int unsigned NC    = SIDE;
    localparam int unsigned AW    = (IMG * IMG > 1) ? $clog2(IMG * IMG) : 1;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state, state_n;
    logic            busy_n, done_n, in_ready_n;
    logic [CW-1:0]   wr_row, wr_row_n, wr_col, wr_col_n;
    logic [CW-1:0]   rd_row, rd_row_n, rd_col, rd_col_n;
    logic            iss_fin, iss_fin_n;
    logic            accept_c, issue_c, last_issue_c, drained_c;
    logic [CW-1:0]   need_rows_c;
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   lane_rd [K];
    logic [K-1:0]    last_pipe;

    // Stored rows required before window row rd_row may be issued
    always_comb begin
`ifdef SA_WINDOW_FEEDER_ZERO_PAD_EN
        need_rows_c = rd_row + CW'(K - 1);
        if (need_rows_c > CW'(IMG)) begin
            need_rows_c = CW'(IMG);
        end
`else
        need_rows_c = rd_row + CW'(K);
`endif
    end

    assign accept_c     = (state == ACTIVE) && in_valid && in_ready;
    assign issue_c      = (state == ACTIVE) && !iss_fin && (wr_row >= need_rows_c);
    assign last_issue_c = issue_c && (rd_row == CW'(NR - 1)) && (rd_col == CW'(NC - 1));
    assign drained_c    = last_pipe[K-1];

    // Frame buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[AW'(32'(wr_row) * IMG + 32'(wr_col))] <= in_data;
        end
    end

    // Column read for every lane at the current issue position (border reads as zero)
    always_comb begin
        for (int k = 0; k < K; k++) begin
            lane_rd[k] = '0;
`ifdef SA_WINDOW_FEEDER_ZERO_PAD_EN
            if ((32'(rd_row) + 32'(k)) != 0 && (32'(rd_row) + 32'(k)) <= IMG &&
                rd_col != '0 && rd_col <= CW'(IMG)) begin
                lane_rd[k] = mem[AW'((32'(rd_row) + 32'(k) - 1) * IMG + 32'(rd_col) - 1)];
            end
`else
            lane_rd[k] = mem[AW'((32'(rd_row) + 32'(k)) * IMG + 32'(rd_col))];
`endif
        end
    end

    // State and control register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
            wr_row   <= '0;
            wr_col   <= '0;
            rd_row   <= '0;
            rd_col   <= '0;
            iss_fin  <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= busy_n;
            done     <= done_n;
            in_ready <= in_ready_n;
            wr_row   <= wr_row_n;
            wr_col   <= wr_col_n;
            rd_row   <= rd_row_n;
            rd_col   <= rd_col_n;
            iss_fin  <= iss_fin_n;
        end
    end

    // Next-state: load start, write/issue counters, end-of-frame drain
    always_comb begin
        state_n    = state;
        busy_n     = busy;
        done_n     = 1'b0;
        in_ready_n = in_ready;
        wr_row_n   = wr_row;
        wr_col_n   = wr_col;
        rd_row_n   = rd_row;
        rd_col_n   = rd_col;
        iss_fin_n  = iss_fin;
        case (state)
            IDLE: begin
                if (load) begin
                    state_n    = ACTIVE;
                    busy_n     = 1'b1;
                    in_ready_n = 1'b1;
                    wr_row_n   = '0;
                    wr_col_n   = '0;
                    rd_row_n   = '0;
                    rd_col_n   = '0;
                    iss_fin_n  = 1'b0;
                end
            end
            ACTIVE: begin
                if (accept_c) begin
                    if (wr_col == CW'(IMG - 1)) begin
                        wr_col_n = '0;
                        wr_row_n = wr_row + CW'(1);
                        if (wr_row == CW'(IMG - 1)) begin
                            in_ready_n = 1'b0;
                        end
                    end else begin
                        wr_col_n = wr_col + CW'(1);
                    end
                end
                if (issue_c) begin
                    if (rd_col == CW'(NC - 1)) begin
                        rd_col_n = '0;
                        if (rd_row == CW'(NR - 1)) begin
                            iss_fin_n = 1'b1;
                        end else begin
                            rd_row_n = rd_row + CW'(1);
                        end
                    end else begin
                        rd_col_n = rd_col + CW'(1);
                    end
                end
                if (drained_c) begin
                    state_n    = IDLE;
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    in_ready_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Start strobe and last-issue tag, the tag aligned with lane K-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srt_sig   <= 1'b0;
            last_pipe <= '0;
        end else begin
            srt_sig      <= issue_c;
            last_pipe[0] <= last_issue_c;
            for (int j = 1; j < K; j++) begin
                last_pipe[j] <= last_pipe[j-1];
            end
        end
    end

    // Per-lane skew line: lane k is delayed k extra cycles; idle slots carry zero
    for (genvar k = 0; k < K; k++) begin : g_lane
        logic [DW-1:0] dpipe [k+1];
        logic          vpipe [k+1];

        // Shift issued column sample through this lane's delay stages
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= k; j++) begin
                    dpipe[j] <= '0;
                    vpipe[j] <= 1'b0;
                end
            end else begin
                dpipe[0] <= issue_c ? lane_rd[k] : '0;
                vpipe[0] <= issue_c;
                for (int j = 1; j <= k; j++) begin
                    dpipe[j] <= dpipe[j-1];
                    vpipe[j] <= vpipe[j-1];
                end
            end
        end

        assign out_bus[k*DW +: DW] = dpipe[k];
        assign out_valid[k]        = vpipe[k];
    end

endmodule

// File: tb/tb_sa_window_feeder.sv
// Directed bench for sa_window_feeder: main instance (16/7/3) and a sweep
// instance (8/5/5); expectations follow SA_WINDOW_FEEDER_ZERO_PAD_EN if defined.
module tb_sa_window_feeder;
    localparam int DW = 16, IMG = 7, K = 3;
    localparam int DWB = 8, IMGB = 5, KB = 5;
`ifdef SA_WINDOW_FEEDER_ZERO_PAD_EN
    localparam int NC  = IMG + 2;
    localparam int NS  = (IMG + 2 - K + 1) * (IMG + 2);
    localparam int NSB = (IMGB + 2 - KB + 1) * (IMGB + 2);
`else
    localparam int NC  = IMG;
    localparam int NS  = (IMG - K + 1) * IMG;
    localparam int NSB = (IMGB - KB + 1) * IMGB;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic a_load, a_in_valid, a_in_ready, a_srt, a_busy, a_done;
    logic [DW-1:0] a_in_data;
    logic [K*DW-1:0] a_bus;
    logic [K-1:0] a_valid;
    logic b_load, b_in_valid, b_in_ready, b_srt, b_busy, b_done;
    logic [DWB-1:0] b_in_data;
    logic [KB*DWB-1:0] b_bus;
    logic [KB-1:0] b_valid;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sa_window_feeder #(.DW(DW), .IMG(IMG), .K(K)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(a_load), .in_valid(a_in_valid),
        .in_data(a_in_data), .in_ready(a_in_ready), .out_bus(a_bus),
        .out_valid(a_valid), .srt_sig(a_srt), .busy(a_busy), .done(a_done));

    sa_window_feeder #(.DW(DWB), .IMG(IMGB), .K(KB)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(b_load), .in_valid(b_in_valid),
        .in_data(b_in_data), .in_ready(b_in_ready), .out_bus(b_bus),
        .out_valid(b_valid), .srt_sig(b_srt), .busy(b_busy), .done(b_done));

    // Monitor state (written only by the monitor process)
    logic clr_req = 1'b0;
    int cyc = 0;
    int ns [K];
    logic [DW-1:0] samp [K][64];
    int first_v [K];
    int last_v [K];
    int zero_err, srt_err, rises, srt_hi, done_cnt, done_cyc, busy_err;
    logic srt_prev, busy_prev;
    int ns_b [KB];
    logic [DWB-1:0] samp_b [KB][32];
    int zero_err_b, done_b;

    // Expected lane-k sample number i for a frame of side img with pixel 10*row+col
    function automatic int exp_pix(input int img, input int k, input int i);
        int nc, r, c, pr, pc;
`ifdef SA_WINDOW_FEEDER_ZERO_PAD_EN
        nc = img + 2; r = i / nc; c = i % nc; pr = r + k; pc = c;
        if (pr == 0 || pr > img || pc == 0 || pc > img) return 0;
        return 10 * (pr - 1) + (pc - 1);
`else
        nc = img; r = i / nc; c = i % nc;
        return 10 * (r + k) + c;
`endif
    endfunction

    function automatic int first_bad(input int k);
        for (int i = 0; i < NS; i++)
            if (samp[k][i] !== DW'(exp_pix(IMG, k, i))) return i;
        return -1;
    endfunction

    function automatic int first_bad_b(input int k);
        for (int i = 0; i < NSB; i++)
            if (samp_b[k][i] !== DWB'(exp_pix(IMGB, k, i))) return i;
        return -1;
    endfunction

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (clr_req) begin
            for (int k = 0; k < K; k++) begin ns[k] = 0; first_v[k] = -1; last_v[k] = -1; end
            for (int k = 0; k < KB; k++) ns_b[k] = 0;
            zero_err = 0; srt_err = 0; rises = 0; srt_hi = 0; done_cnt = 0;
            done_cyc = -1; busy_err = 0; srt_prev = a_srt; busy_prev = a_busy;
            zero_err_b = 0; done_b = 0;
        end else begin
            for (int k = 0; k < K; k++) begin
                if (a_valid[k]) begin
                    if (ns[k] < 64) samp[k][ns[k]] = a_bus[k*DW +: DW];
                    if (ns[k] == 0) first_v[k] = cyc;
                    last_v[k] = cyc;
                    ns[k]++;
                end else if (a_bus[k*DW +: DW] !== '0) zero_err++;
            end
            if (a_srt !== a_valid[0]) srt_err++;
            if (a_srt && !srt_prev) rises++;
            if (a_srt) srt_hi++;
            srt_prev = a_srt;
            if (a_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (a_busy !== 1'b0 || busy_prev !== 1'b1) busy_err++;
            end
            busy_prev = a_busy;
            for (int k = 0; k < KB; k++) begin
                if (b_valid[k]) begin
                    if (ns_b[k] < 32) samp_b[k][ns_b[k]] = b_bus[k*DWB +: DWB];
                    ns_b[k]++;
                end else if (b_bus[k*DWB +: DWB] !== '0) zero_err_b++;
            end
            if (b_done) done_b++;
        end
    end

    task automatic clr_mon();
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
    endtask

    task automatic start_a();
        @(posedge clk); #1;
        a_load = 1'b1;
        @(posedge clk); #1;
        a_load = 1'b0;
    endtask

    // Stream pixels into instance A; optional input gap and a stray load pulse
    task automatic stream(input int gap_after, input int gap_len, input int load_at, input int stop_at);
        int idx, gap, guard;
        bit acc, did_load;
        idx = 0; gap = 0; guard = 0; did_load = 0;
        while (idx < stop_at && guard < 3000) begin
            guard++;
            if (gap > 0) begin
                a_in_valid = 1'b0;
                gap--;
            end else begin
                a_in_valid = 1'b1;
                a_in_data = DW'(10 * (idx / IMG) + idx % IMG);
            end
            a_load = (idx == load_at && !did_load);
            if (a_load) did_load = 1;
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx == gap_after) gap = gap_len;
            end
        end
        a_in_valid = 1'b0;
        a_load = 1'b0;
        n_checks++;
        if (idx != stop_at) begin
            n_fail++;
            $display("FAIL stream_timeout: accepted %0d, required %0d", idx, stop_at);
        end
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_load = 0; a_in_valid = 0; a_in_data = '0;
        b_load = 0; b_in_valid = 0; b_in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, want 0", a_in_ready); end
        n_checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b, want 00", a_busy, a_done); end
        n_checks++; if (a_valid !== '0 || a_srt !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b/%b, want 0", a_valid, a_srt); end
        n_checks++; if (a_bus !== '0) begin n_fail++; $display("FAIL reset_bus: got %h, want 0", a_bus); end
        n_checks++; if (b_valid !== '0 || b_bus !== '0) begin n_fail++; $display("FAIL reset_b: got %b/%h, want 0", b_valid, b_bus); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_continuous();
        int extra, bad;
        clr_mon();
        start_a();
        stream(-1, 0, -1, IMG * IMG);
        extra = 0;
        a_in_valid = 1'b1; a_in_data = DW'(16'h7777);
        repeat (3) begin
            @(negedge clk); if (a_in_ready) extra++;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL cont_in_ready_after_frame: extra accepts %0d, want 0", extra); end
        wait_done_a();
        for (int k = 0; k < K; k++) begin
            n_checks++; if (ns[k] != NS) begin n_fail++; $display("FAIL cont_count lane %0d: got %0d, want %0d", k, ns[k], NS); end
            bad = first_bad(k);
            n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL cont_data lane %0d idx %0d: got %0d, want %0d", k, bad, samp[k][bad], exp_pix(IMG, k, bad)); end
        end
        for (int k = 1; k < K; k++) begin
            n_checks++; if (first_v[k] != first_v[0] + k) begin n_fail++; $display("FAIL cont_skew lane %0d: first at %0d, want %0d", k, first_v[k], first_v[0] + k); end
        end
        n_checks++; if (srt_hi != NS || rises != 1) begin n_fail++; $display("FAIL cont_srt: high %0d in %0d runs, want %0d in 1", srt_hi, rises, NS); end
        n_checks++; if (samp[0][NS-1] !== DW'(exp_pix(IMG, 0, NS - 1)) || samp[2][NS-1] !== DW'(exp_pix(IMG, 2, NS - 1)))
            begin n_fail++; $display("FAIL cont_last: got %0d/%0d, want %0d/%0d", samp[0][NS-1], samp[2][NS-1], exp_pix(IMG, 0, NS - 1), exp_pix(IMG, 2, NS - 1)); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL cont_done_count: got %0d, want 1", done_cnt); end
        n_checks++; if (done_cyc != last_v[K-1] + 1) begin n_fail++; $display("FAIL cont_done_timing: at %0d, want %0d", done_cyc, last_v[K-1] + 1); end
        n_checks++; if (busy_err != 0) begin n_fail++; $display("FAIL cont_busy_fall: errors %0d, want 0", busy_err); end
        n_checks++; if (zero_err != 0 || srt_err != 0) begin n_fail++; $display("FAIL cont_idle_zero: zero_err %0d srt_err %0d, want 0", zero_err, srt_err); end
    endtask

    task automatic test_underflow_stall();
        int bad;
        clr_mon();
        start_a();
        stream(24, 5, -1, IMG * IMG);
        wait_done_a();
        for (int k = 0; k < K; k++) begin
            n_checks++; if (ns[k] != NS) begin n_fail++; $display("FAIL stall_count lane %0d: got %0d, want %0d", k, ns[k], NS); end
            bad = first_bad(k);
            n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL stall_data lane %0d idx %0d: got %0d, want %0d", k, bad, samp[k][bad], exp_pix(IMG, k, bad)); end
        end
        n_checks++; if (rises != 2 || srt_hi != NS) begin n_fail++; $display("FAIL stall_runs: %0d runs %0d high, want 2 runs %0d high", rises, srt_hi, NS); end
        n_checks++; if (samp[0][NC] !== DW'(exp_pix(IMG, 0, NC))) begin n_fail++; $display("FAIL stall_resume: got %0d, want %0d", samp[0][NC], exp_pix(IMG, 0, NC)); end
        n_checks++; if (zero_err != 0 || done_cnt != 1) begin n_fail++; $display("FAIL stall_zero_done: zero_err %0d done %0d, want 0/1", zero_err, done_cnt); end
    endtask

    task automatic test_load_while_busy();
        int bad;
        clr_mon();
        start_a();
        stream(-1, 0, 30, IMG * IMG);
        wait_done_a();
        for (int k = 0; k < K; k++) begin
            bad = first_bad(k);
            n_checks++; if (ns[k] != NS || bad >= 0) begin n_fail++; $display("FAIL load_busy lane %0d: count %0d bad idx %0d, want %0d/-1", k, ns[k], bad, NS); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL load_busy_done: got %0d, want 1", done_cnt); end
    endtask

    task automatic test_reset_mid_stream();
        int bad;
        clr_mon();
        start_a();
        stream(-1, 0, -1, 38);
        n_checks++; if (a_busy !== 1'b1 || a_valid[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset: busy %b valid0 %b, want 1/1", a_busy, a_valid[0]); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (a_valid !== '0 || a_bus !== '0 || a_srt !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: valid %b bus %h srt %b, want 0", a_valid, a_bus, a_srt); end
        n_checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: busy %b done %b rdy %b, want 0", a_busy, a_done, a_in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr_mon();
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != 0 || ns[0] != 0) begin n_fail++; $display("FAIL mid_no_done: done %0d samples %0d, want 0/0", done_cnt, ns[0]); end
        clr_mon();
        start_a();
        stream(-1, 0, -1, IMG * IMG);
        wait_done_a();
        for (int k = 0; k < K; k++) begin
            bad = first_bad(k);
            n_checks++; if (ns[k] != NS || bad >= 0) begin n_fail++; $display("FAIL mid_fresh lane %0d: count %0d bad idx %0d, want %0d/-1", k, ns[k], bad, NS); end
        end
        n_checks++; if (done_cnt != 1 || rises != 1) begin n_fail++; $display("FAIL mid_fresh_done: done %0d runs %0d, want 1/1", done_cnt, rises); end
    endtask

    task automatic test_param_sweep();
        int idx, guard, bad;
        bit acc;
        clr_mon();
        @(posedge clk); #1; b_load = 1'b1;
        @(posedge clk); #1; b_load = 1'b0;
        idx = 0; guard = 0;
        while (idx < IMGB * IMGB && guard < 500) begin
            guard++;
            b_in_valid = 1'b1;
            b_in_data = DWB'(10 * (idx / IMGB) + idx % IMGB);
            @(negedge clk); acc = b_in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        b_in_valid = 1'b0;
        n_checks++; if (idx != IMGB * IMGB) begin n_fail++; $display("FAIL sweep_accept: got %0d, want %0d", idx, IMGB * IMGB); end
        for (int i = 0; i < 300 && done_b == 0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < KB; k++) begin
            bad = first_bad_b(k);
            n_checks++; if (ns_b[k] != NSB || bad >= 0) begin n_fail++; $display("FAIL sweep lane %0d: count %0d bad idx %0d, want %0d/-1", k, ns_b[k], bad, NSB); end
        end
        n_checks++; if (samp_b[4][0] !== DWB'(exp_pix(IMGB, 4, 0))) begin n_fail++; $display("FAIL sweep_lane4_first: got %0d, want %0d", samp_b[4][0], exp_pix(IMGB, 4, 0)); end
        n_checks++; if (done_b != 1 || zero_err_b != 0) begin n_fail++; $display("FAIL sweep_done_zero: done %0d zero_err %0d, want 1/0", done_b, zero_err_b); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_underflow_stall();
        test_load_while_busy();
        test_reset_mid_stream();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
